// File: rtl/dispatch_buffer_pkg.sv
// Shared constants for the decode -> dispatch interface.
// Queue codes, ctrl field positions and packet field widths are used by
// decode and by dispatch_buffer alike so both sides agree on the encoding.
package dispatch_buffer_pkg;

    // Target issue queue carried in ctrl[2:1]
    typedef enum logic [1:0] {
        QUEUE_NONE = 2'b00,
        QUEUE_MEMQ = 2'b01,
        QUEUE_ALUQ = 2'b10
    } queue_e;

    // ctrl = {pry[1:0], queue[1:0], valid}
    localparam int unsigned CTRL_W        = 5;
    localparam int unsigned CTRL_VALID    = 0;
    localparam int unsigned CTRL_QUEUE_LO = 1;
    localparam int unsigned CTRL_QUEUE_HI = 2;
    localparam int unsigned CTRL_PRY_LO   = 3;
    localparam int unsigned CTRL_PRY_HI   = 4;

    // Packet field widths; packet = {uop, regs, func, imm, pry, brmask}
    localparam int unsigned UOP_W  = 7;
    localparam int unsigned REGS_W = 15;
    localparam int unsigned FUNC_W = 10;
    localparam int unsigned IMM_W  = 32;
    localparam int unsigned PRY_W  = 2;

    // Packet width excluding the branch mask (7+15+10+32+2)
    localparam int unsigned PKT_BASE_W = UOP_W + REGS_W + FUNC_W + IMM_W + PRY_W;

    // Only the MEMQ code goes to the memory queue; every other code is ALU work
    function automatic logic is_memq(input logic [1:0] queue);
        return queue == QUEUE_MEMQ;
    endfunction

endpackage

// File: rtl/dispatch_fifo_mem.sv
// Packet storage for dispatch_buffer: DEPTH x WIDTH register array,
// one synchronous write port, one asynchronous read port.
module dispatch_fifo_mem #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry when enabled; contents need no reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dispatch_buffer.sv
// In-order dispatch FIFO between decode and the MEMQ/ALUQ issue queues.
// The head entry is routed by its queue code and leaves only when its own
// queue is ready, so a blocked head holds back every younger entry.
// Optional feature macro: DISPATCH_BYPASS_EN (empty-buffer same-cycle bypass).
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned WIDTH_BRM = 6,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [UOP_W-1:0]     i_uop,
    input  logic [REGS_W-1:0]    i_regs,
    input  logic [FUNC_W-1:0]    i_func,
    input  logic [CTRL_W-1:0]    i_ctrl,
    input  logic [IMM_W-1:0]     i_imm,
    input  logic [WIDTH_BRM-1:0] i_brmask,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_mem_valid,
    input  logic                 i_mem_ready,
    output logic                 o_alu_valid,
    input  logic                 i_alu_ready,
    output logic [UOP_W-1:0]     o_uop,
    output logic [REGS_W-1:0]    o_regs,
    output logic [FUNC_W-1:0]    o_func,
    output logic [IMM_W-1:0]     o_imm,
    output logic [PRY_W-1:0]     o_pry,
    output logic [WIDTH_BRM-1:0] o_brmask,
    output logic [CW-1:0]        o_count
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned PKT_W = PKT_BASE_W + WIDTH_BRM;

    // Pointer / occupancy state
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_route_mem;

    // Datapath wires
    logic [PKT_W-1:0] w_in_pkt;
    logic [PKT_W-1:0] w_fifo_pkt;
    logic [PKT_W-1:0] w_head_pkt;
    logic             w_in_mem;
    logic             w_fifo_valid;
    logic             w_head_valid;
    logic             w_head_mem;
    logic             w_enq;
    logic             w_deq;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    assign w_in_pkt = {i_uop, i_regs, i_func, i_imm,
                       i_ctrl[CTRL_PRY_HI:CTRL_PRY_LO], i_brmask};
    assign w_in_mem = is_memq(i_ctrl[CTRL_QUEUE_HI:CTRL_QUEUE_LO]);

    // Full is judged from registered occupancy only, never from this cycle's readies
    assign o_stall = (r_count == CW'(DEPTH));
    assign w_enq   = i_ctrl[CTRL_VALID] & ~o_stall;

    assign w_fifo_valid = (r_count != '0);

`ifdef DISPATCH_BYPASS_EN
    // Empty buffer: present the incoming packet at the head in the same cycle.
    // A flush in that cycle kills the bypass so nothing is offered downstream.
    assign w_bypass     = ~w_fifo_valid & w_enq & ~i_flush;
    assign w_head_valid = w_fifo_valid | w_bypass;
    assign w_head_mem   = w_bypass ? w_in_mem : r_route_mem[r_rd_ptr];
    assign w_head_pkt   = w_bypass ? w_in_pkt : w_fifo_pkt;
`else
    assign w_bypass     = 1'b0;
    assign w_head_valid = w_fifo_valid;
    assign w_head_mem   = r_route_mem[r_rd_ptr];
    assign w_head_pkt   = w_fifo_pkt;
`endif

    assign o_mem_valid = w_head_valid &  w_head_mem;
    assign o_alu_valid = w_head_valid & ~w_head_mem;
    assign {o_uop, o_regs, o_func, o_imm, o_pry, o_brmask} = w_head_pkt;
    assign o_count = r_count;

    assign w_deq = (o_mem_valid & i_mem_ready) | (o_alu_valid & i_alu_ready);

    // A bypassed packet that is consumed immediately never occupies an entry;
    // a bypassed packet whose queue is not ready is stored like any other.
    assign w_push = w_enq & ~i_flush & ~i_rst & ~(w_bypass & w_deq);
    assign w_pop  = w_deq & ~w_bypass;

    dispatch_fifo_mem #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_in_pkt),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_fifo_pkt)
    );

    // Record each stored entry's target queue alongside its payload
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_route_mem[r_wr_ptr] <= w_in_mem;
        end
    end

    // Pointer and occupancy update; flush empties the buffer by aligning read to write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: directed vector table, a wrap
// sequence, a reset sequence, and randomized traffic against a queue model.
module tb_dispatch_buffer;

    localparam int unsigned BRM   = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned PKT_W = 66 + BRM;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      uop;
    logic [14:0]     regs;
    logic [9:0]      func;
    logic [4:0]      ctrl;
    logic [31:0]     imm;
    logic [BRM-1:0]  brmask;
    logic            flush;
    logic            stall;
    logic            mem_valid;
    logic            mem_ready;
    logic            alu_valid;
    logic            alu_ready;
    logic [6:0]      o_uop;
    logic [14:0]     o_regs;
    logic [9:0]      o_func;
    logic [31:0]     o_imm;
    logic [1:0]      o_pry;
    logic [BRM-1:0]  o_brmask;
    logic [CW-1:0]   count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    dispatch_buffer #(
        .WIDTH_BRM (BRM),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uop       (uop),
        .i_regs      (regs),
        .i_func      (func),
        .i_ctrl      (ctrl),
        .i_imm       (imm),
        .i_brmask    (brmask),
        .i_flush     (flush),
        .o_stall     (stall),
        .o_mem_valid (mem_valid),
        .i_mem_ready (mem_ready),
        .o_alu_valid (alu_valid),
        .i_alu_ready (alu_ready),
        .o_uop       (o_uop),
        .o_regs      (o_regs),
        .o_func      (o_func),
        .o_imm       (o_imm),
        .o_pry       (o_pry),
        .o_brmask    (o_brmask),
        .o_count     (count)
    );

    typedef struct {
        logic        enq;
        logic [1:0]  q;
        logic [31:0] imm;
        logic        mr;
        logic        ar;
        logic        fl;
        logic        e_mv;
        logic        e_av;
        logic [CW-1:0] e_cnt;
        logic        e_st;
        logic        ck_imm;
        logic [31:0] e_imm;
    } vec_t;

    typedef struct {
        logic             mem;
        logic [PKT_W-1:0] data;
    } mpkt_t;

    vec_t  vecs[$];
    mpkt_t model_q[$];

    function automatic vec_t mk(input logic enq, input logic [1:0] q, input logic [31:0] im,
                                input logic mr, input logic ar, input logic fl,
                                input logic e_mv, input logic e_av, input int e_cnt,
                                input logic e_st, input logic ck, input logic [31:0] e_imm);
        vec_t v;
        v.enq = enq; v.q = q; v.imm = im; v.mr = mr; v.ar = ar; v.fl = fl;
        v.e_mv = e_mv; v.e_av = e_av; v.e_cnt = CW'(e_cnt); v.e_st = e_st;
        v.ck_imm = ck; v.e_imm = e_imm;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic enq, input logic [1:0] q, input logic [31:0] im,
                         input logic mr, input logic ar, input logic fl);
        ctrl      = {2'b00, q, enq};
        imm       = im;
        mem_ready = mr;
        alu_ready = ar;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mpkt_t       in_p;
        mpkt_t       head;
        logic        hv;
        logic        byp;
        logic        deq;
        logic        enq_acc;
        logic        r_enq;
        logic [1:0]  r_q;

        rst = 1'b1;
        uop = '0; regs = '0; func = '0; brmask = '0;
        drive(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #7;
        check("reset_count", 128'(count), 128'd0);
        check("reset_stall", 128'(stall), 128'd0);
        check("reset_memv",  128'(mem_valid), 128'd0);
        check("reset_aluv",  128'(alu_valid), 128'd0);
        tick();

`ifndef DISPATCH_BYPASS_EN
        // enq, q, imm, mr, ar, fl | mv, av, cnt, stall, chk_imm, imm
        // 1: ADDI to ALUQ, drained next cycle
        vecs.push_back(mk(1, 2'b10, 100, 0, 1, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00,   0, 0, 1, 0,  0, 1, 1, 0, 1, 100));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // 2: LW held 3 cycles by MEMQ, then accepted
        vecs.push_back(mk(1, 2'b01, 200, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  1, 0, 1, 0, 1, 200));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  1, 0, 1, 0, 1, 200));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  1, 0, 1, 0, 1, 200));
        vecs.push_back(mk(0, 2'b00,   0, 1, 0, 0,  1, 0, 1, 0, 1, 200));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // 3: fill to DEPTH, fifth packet refused, in-order drain (queue codes 10/00/11 all ALU)
        vecs.push_back(mk(1, 2'b10,   1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b00,   2, 0, 0, 0,  0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 2'b11,   3, 0, 0, 0,  0, 1, 2, 0, 1, 1));
        vecs.push_back(mk(1, 2'b10,   4, 0, 0, 0,  0, 1, 3, 0, 1, 1));
        vecs.push_back(mk(1, 2'b10,   5, 0, 0, 0,  0, 1, 4, 1, 1, 1));
        vecs.push_back(mk(0, 2'b00,   0, 0, 1, 0,  0, 1, 4, 1, 1, 1));
        vecs.push_back(mk(0, 2'b00,   0, 0, 1, 0,  0, 1, 3, 0, 1, 2));
        vecs.push_back(mk(0, 2'b00,   0, 0, 1, 0,  0, 1, 2, 0, 1, 3));
        vecs.push_back(mk(0, 2'b00,   0, 0, 1, 0,  0, 1, 1, 0, 1, 4));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // 4: LW head blocks a ready ALU entry behind it
        vecs.push_back(mk(1, 2'b01, 300, 0, 1, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 301, 0, 1, 0,  1, 0, 1, 0, 1, 300));
        vecs.push_back(mk(0, 2'b00,   0, 0, 1, 0,  1, 0, 2, 0, 1, 300));
        vecs.push_back(mk(0, 2'b00,   0, 1, 1, 0,  1, 0, 2, 0, 1, 300));
        vecs.push_back(mk(0, 2'b00,   0, 1, 1, 0,  0, 1, 1, 0, 1, 301));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // 5: count 3, enqueue together with flush
        vecs.push_back(mk(1, 2'b10, 400, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 401, 0, 0, 0,  0, 1, 1, 0, 1, 400));
        vecs.push_back(mk(1, 2'b10, 402, 0, 0, 0,  0, 1, 2, 0, 1, 400));
        vecs.push_back(mk(1, 2'b10, 403, 0, 0, 1,  0, 1, 3, 0, 1, 400));
        vecs.push_back(mk(0, 2'b00,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00,   0, 1, 1, 0,  0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].enq, vecs[i].q, vecs[i].imm, vecs[i].mr, vecs[i].ar, vecs[i].fl);
            #7;
            check($sformatf("vec%0d_memv", i), 128'(mem_valid), 128'(vecs[i].e_mv));
            check($sformatf("vec%0d_aluv", i), 128'(alu_valid), 128'(vecs[i].e_av));
            check($sformatf("vec%0d_count", i), 128'(count), 128'(vecs[i].e_cnt));
            check($sformatf("vec%0d_stall", i), 128'(stall), 128'(vecs[i].e_st));
            if (vecs[i].ck_imm)
                check($sformatf("vec%0d_imm", i), 128'(o_imm), 128'(vecs[i].e_imm));
            tick();
        end
`endif

        // 6: wrap with back-to-back enqueue/dequeue, imm 0..9 in order
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b10, 32'(i), 1'b0, 1'b1, 1'b0);
            #7;
`ifdef DISPATCH_BYPASS_EN
            check($sformatf("wrap%0d_aluv", i), 128'(alu_valid), 128'd1);
            check($sformatf("wrap%0d_imm", i), 128'(o_imm), 128'(i));
`else
            if (i == 0) begin
                check("wrap0_aluv", 128'(alu_valid), 128'd0);
            end else begin
                check($sformatf("wrap%0d_aluv", i), 128'(alu_valid), 128'd1);
                check($sformatf("wrap%0d_imm", i), 128'(o_imm), 128'(i - 1));
                check($sformatf("wrap%0d_count", i), 128'(count), 128'd1);
            end
`endif
            tick();
        end
        drive(1'b0, 2'b00, 32'd0, 1'b0, 1'b1, 1'b0);
        #7;
`ifndef DISPATCH_BYPASS_EN
        check("wrap_last_imm", 128'(o_imm), 128'd9);
        check("wrap_last_aluv", 128'(alu_valid), 128'd1);
`endif
        tick();
        drive(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0);
        #7;
        check("wrap_empty", 128'(count), 128'd0);
        tick();

        // Reset mid-operation: two entries held, then reset with an enqueue present
        drive(1'b1, 2'b01, 32'd77, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0);
        #7;
        check("midrst_count", 128'(count), 128'd0);
        check("midrst_valid", 128'({mem_valid, alu_valid}), 128'd0);
        tick();

        // Randomized traffic against a plain in-order queue model
        for (int n = 0; n < 600; n++) begin
            r_enq  = ($urandom_range(0, 9) < 6);
            r_q    = 2'($urandom_range(0, 3));
            uop    = 7'($urandom);
            regs   = 15'($urandom);
            func   = 10'($urandom);
            brmask = BRM'($urandom);
            ctrl   = {2'($urandom), r_q, r_enq};
            imm    = $urandom;
            mem_ready = $urandom_range(0, 1);
            alu_ready = $urandom_range(0, 1);
            flush     = ($urandom_range(0, 29) == 0);

            in_p.mem  = (r_q == 2'b01);
            in_p.data = {uop, regs, func, imm, ctrl[4:3], brmask};
            enq_acc   = r_enq && (model_q.size() < DEPTH);
            byp = 1'b0;
            hv  = 1'b0;
            head = in_p;
            if (model_q.size() > 0) begin
                hv   = 1'b1;
                head = model_q[0];
            end
`ifdef DISPATCH_BYPASS_EN
            else if (enq_acc && !flush) begin
                hv  = 1'b1;
                byp = 1'b1;
            end
`endif
            #7;
            check($sformatf("rnd%0d_count", n), 128'(count), 128'(model_q.size()));
            check($sformatf("rnd%0d_stall", n), 128'(stall), 128'(model_q.size() == DEPTH));
            check($sformatf("rnd%0d_memv", n), 128'(mem_valid), 128'(hv && head.mem));
            check($sformatf("rnd%0d_aluv", n), 128'(alu_valid), 128'(hv && !head.mem));
            if (hv)
                check($sformatf("rnd%0d_payload", n),
                      128'({o_uop, o_regs, o_func, o_imm, o_pry, o_brmask}), 128'(head.data));

            deq = hv && (head.mem ? mem_ready : alu_ready);
            if (flush) begin
                model_q.delete();
            end else begin
                if (deq && !byp)
                    void'(model_q.pop_front());
                if (enq_acc && !(byp && deq))
                    model_q.push_back(in_p);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
